uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter; the CPU-to-serial counterpart of the receive-side memory-mapped IO.

---
 rtl/uart_tx_mmio.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped UART transmitter on the data-memory bus. CPU stores to
// TXDATA queue bytes in a small FIFO. The FIFO drains as 8N1 frames, LSB
// first. CPU loads from STATUS return a word that software polls.
//
// Register map (word addresses; address[1:0] ignored):
//   BASE_ADDR + 0 : TXDATA  (write: push WriteData[7:0]; reads return 0)
//   BASE_ADDR + 4 : STATUS  (read : {24'b0, count[3:0], overflow, tx_busy,
//                                    empty, full}
//                            write: WriteData[3]=1 clears overflow)
//
// Ports:
//   clk        in   1   system clock, all state on the rising edge
//   reset      in   1   asynchronous, active-low reset
//   memWrite   in   1   store strobe, one write per asserted cycle
//   memRead    in   1   load strobe
//   address    in   32  bus address
//   WriteData  in   32  store data
//   ReadData   out  32  status readback (combinational), 0 when not selected
//   tx         out  1   serial line, idle high
//   tx_busy    out  1   high while a frame is on the line
//   dbg_state  out  2   current transmit FSM state (debug observation)
//
// Bus handshake: there is no valid/ready pair. memWrite and memRead are
// single-cycle strobes that are always accepted. The block never stalls the
// CPU. A store to a full FIFO is dropped and recorded in the sticky overflow
// flag. Software is expected to poll STATUS.full before writing.
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [31:0] address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        tx_busy,
  output logic [1:0]  dbg_state
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic sel_data;
  logic sel_stat;

  assign sel_data = (address[31:2] == BASE_ADDR[31:2]);
  assign sel_stat = (address[31:2] == (BASE_ADDR[31:2] + 30'd1));

  // Byte-lane bits and upper store data have no meaning for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, address[1:0], WriteData[31:8]};

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // Fullness is taken from the registered count. A pop on the same edge does
  // not make room for a push that arrived while full.
  assign push = memWrite & sel_data & ~fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    // Pointers are PTR_W bits wide and FIFO_DEPTH is a power of two, so they
    // wrap on their own.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Set and clear use different addresses, so they never collide.
    if (memWrite && sel_data && fifo_full) begin
      ovf_d = 1'b1;
    end else if (memWrite && sel_stat && WriteData[3]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset. The count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    // The bit timer runs in every state except IDLE. It restarts at each bit
    // boundary, so every bit lasts exactly CLKS_PER_BIT cycles.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Put the next bit on the line while the shift register moves along.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Back-to-back frames: the next start bit follows the stop bit
            // with no idle cycle in between.
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [3:0] count4;
  assign count4 = 4'(count_q);

  assign ReadData  = (memRead && sel_stat)
                   ? {24'b0, count4, ovf_q, busy_q, fifo_empty, fifo_full}
                   : 32'b0;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;

  // ---------------------------------------------------------------- clock/reset
  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        memWrite  = 1'b0;
  logic        memRead   = 1'b0;
  logic [31:0] address   = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        tx;
  logic        tx_busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .address   (address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------- model
  // exp_q holds the queued bytes. line_q holds the per-cycle line levels
  // still to come for the frame in flight.
  logic [7:0] exp_q[$];
  logic       line_q[$];
  logic       m_tx  = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_byte;
  logic       m_bit;
  bit         m_was_full;
  bit         m_start;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      line_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_was_full = (exp_q.size() == DEPTH);
      m_start    = (line_q.size() == 0) && (exp_q.size() != 0);
      if (m_start) begin
        m_byte = exp_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          m_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[k-1];
          for (int c = 0; c < CPB; c++) line_q.push_back(m_bit);
        end
      end
      if (memWrite && ((address & ~32'h3) == BASE)) begin
        if (m_was_full) m_ovf = 1'b1;
        else exp_q.push_back(WriteData[7:0]);
      end
      if (memWrite && ((address & ~32'h3) == BASE + 32'd4) && WriteData[3]) m_ovf = 1'b0;
      if (line_q.size() != 0) begin
        m_tx   = line_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- compare
  logic [31:0] exp_rd;
  int          qsz;
  logic [31:0] qsz_v;

  always @(negedge clk) begin
    if (chk_en) begin
      qsz   = exp_q.size();
      qsz_v = qsz;
      if (memRead && ((address & ~32'h3) == BASE + 32'd4))
        exp_rd = {24'b0, qsz_v[3:0], m_ovf, m_busy, (qsz == 0), (qsz == DEPTH)};
      else
        exp_rd = 32'h0;
      check("cyc_tx", {31'b0, tx}, {31'b0, m_tx});
      check("cyc_busy", {31'b0, tx_busy}, {31'b0, m_busy});
      check("cyc_rdata", ReadData, exp_rd);
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memWrite  = 1'b1;
    address   = a;
    WriteData = d;
    @(posedge clk); #1;
    memWrite  = 1'b0;
  endtask

  task automatic load_check(input logic [31:0] a, input logic [31:0] exp,
                            input string name);
    memRead = 1'b1;
    address = a;
    @(negedge clk);
    check(name, ReadData, exp);
    @(posedge clk); #1;
    memRead = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    repeat (2) begin @(posedge clk); #1; end
    while (tx_busy && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'b0, tx_busy}, 32'h0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic       rec_tx   [0:59];
  logic       rec_busy [0:59];
  logic [9:0] got_bits;
  int         first_low;
  int         busy_cnt;
  int         falls;
  int         low_cnt;
  logic       prev_busy;

  initial begin
    // 1. reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, tx_busy}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    load_check(BASE + 32'd4, 32'h0000_0002, "rst_status");

    // 2. single byte 0xA5: waveform and tx_busy duration
    store(BASE, 32'h0000_00A5);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rec_tx[i]   = tx;
      rec_busy[i] = tx_busy;
    end
    first_low = -1;
    busy_cnt  = 0;
    for (int i = 0; i < 60; i++) begin
      if (first_low < 0 && rec_tx[i] == 1'b0) first_low = i;
      if (rec_busy[i]) busy_cnt++;
    end
    check("a5_latency", first_low, 32'd1);
    check("a5_busy_cycles", busy_cnt, 32'd40);
    for (int j = 0; j < 10; j++) got_bits[j] = rec_tx[1 + CPB*j + 1];
    check("a5_bits", {22'b0, got_bits}, {22'b0, 10'b1101001010});
    @(posedge clk); #1;

    // 3. five back-to-back stores while idle: all accepted, frames gap-free
    for (int i = 0; i < 5; i++) store(BASE, 32'h11 * (i + 1));
    load_check(BASE + 32'd4, 32'h0000_0045, "burst5_status");
    busy_cnt  = 0;
    falls     = 0;
    prev_busy = 1'b1;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      if (prev_busy && !tx_busy) falls++;
      prev_busy = tx_busy;
    end
    check("burst5_busy_cycles", busy_cnt, 32'd196);
    check("burst5_no_gap", falls, 32'd1);
    @(posedge clk); #1;
    load_check(BASE + 32'd4, 32'h0000_0002, "burst5_no_ovf");

    // 4. six stores with the line busy: four queued, overflow sticky, clear
    store(BASE, 32'h0000_00A0);
    for (int i = 0; i < 6; i++) store(BASE, 32'hC0 + i);
    load_check(BASE + 32'd4, 32'h0000_004D, "ovf_status");
    store(BASE + 32'd4, 32'h0000_0008);
    load_check(BASE + 32'd4, 32'h0000_0045, "ovf_cleared");
    wait_idle(400, "ovf_drain");
    load_check(BASE + 32'd4, 32'h0000_0002, "ovf_drained");

    // 5. reset in the middle of a data bit
    store(BASE, 32'h0000_005A);
    store(BASE, 32'h0000_00C3);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    check("midrst_busy", {31'b0, tx_busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    load_check(BASE + 32'd4, 32'h0000_0002, "midrst_status");
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    check("midrst_silent", low_cnt, 32'd0);
    @(posedge clk); #1;

    // 6. neighbouring addresses have no effect; low address bits ignored
    store(BASE + 32'd8, 32'h0000_0077);
    store(BASE - 32'd4, 32'h0000_0066);
    load_check(BASE + 32'd8, 32'h0, "rd_base_p8");
    load_check(BASE - 32'd4, 32'h0, "rd_base_m4");
    load_check(BASE, 32'h0, "rd_txdata");
    load_check(BASE + 32'd7, 32'h0000_0002, "rd_status_lowbits");
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    check("other_addr_silent", low_cnt, 32'd0);
    @(posedge clk); #1;
    store(BASE + 32'd3, 32'h0000_003C);
    wait_idle(100, "lowbits_frame_done");
    load_check(BASE + 32'd4, 32'h0000_0002, "final_status");

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
